// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Requester byte handshakes and UART TX FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic       uart_full;
  logic       uart_write;
  logic [7:0] uart_data;

  modport master (
    output req_valid, req_data0, req_data1, req_last, uart_full,
    input  req_ready, uart_write, uart_data
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_last, uart_full,
    output req_ready, uart_write, uart_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Grants one of two requesters the UART TX FIFO per message, with
//            round-robin tie break, idle timeout and message length limit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 360,
  parameter int MAX_MSG_LEN    = 64
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus,
  output logic [1:0]       grant,
  output logic [7:0]       timeout_count,
  output logic             overlength
);

  localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_BYTE_W = $clog2(MAX_MSG_LEN + 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);
  localparam logic [c_BYTE_W-1:0] c_BYTE_LAST = c_BYTE_W'(MAX_MSG_LEN - 1);
  localparam logic [c_BYTE_W-1:0] c_BYTE_ONE  = c_BYTE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_served;
  logic [c_BYTE_W-1:0] r_byte_cnt;
  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic                r_uart_write;
  logic [7:0]          r_uart_data;
  logic [7:0]          r_timeout_count;
  logic                r_overlength;

  logic                w_owner;
  logic                w_xfer;
  logic [1:0]          w_ready;
  logic [1:0]          w_grant;
  logic [7:0]          w_data;
  logic                w_last;
  logic                w_release;
  logic                w_len_rel;
  logic                w_timeout_rel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_owner       = 1'b0;
    w_xfer        = 1'b0;
    w_ready       = 2'b00;
    w_grant       = 2'b00;
    w_data        = 8'h00;
    w_last        = 1'b0;
    w_release     = 1'b0;
    w_len_rel     = 1'b0;
    w_timeout_rel = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On a tie the requester that was not served last wins.
        if (bus.req_valid == 2'b11) begin
          w_next_state = r_last_served ? ST_GRANT0 : ST_GRANT1;
        end else if (bus.req_valid[0]) begin
          w_next_state = ST_GRANT0;
        end else if (bus.req_valid[1]) begin
          w_next_state = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        w_owner = (r_state == ST_GRANT1);
        w_grant = w_owner ? 2'b10 : 2'b01;
        w_data  = w_owner ? bus.req_data1 : bus.req_data0;
        w_last  = bus.req_last[w_owner];
        w_xfer  = bus.req_valid[w_owner] & ~bus.uart_full;
        w_ready = w_owner ? {w_xfer, 1'b0} : {1'b0, w_xfer};
        // A last marker outranks both the length limit and the timeout.
        if (w_xfer && w_last) begin
          w_release = 1'b1;
        end else if (w_xfer && (r_byte_cnt == c_BYTE_LAST)) begin
          w_release = 1'b1;
          w_len_rel = 1'b1;
        end else if (!w_xfer && (r_idle_cnt == c_IDLE_LAST)) begin
          w_release     = 1'b1;
          w_timeout_rel = 1'b1;
        end
        if (w_release) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_served   <= 1'b1;
      r_byte_cnt      <= '0;
      r_idle_cnt      <= '0;
      r_uart_write    <= 1'b0;
      r_uart_data     <= 8'h00;
      r_timeout_count <= 8'h00;
      r_overlength    <= 1'b0;
    end else begin
      r_uart_write <= w_xfer;
      if (w_xfer) begin
        r_uart_data <= w_data;
      end
      // Holding the counters clear through IDLE makes every grant start at zero.
      if (r_state == ST_IDLE) begin
        r_byte_cnt <= '0;
        r_idle_cnt <= '0;
      end else if (w_xfer) begin
        r_byte_cnt <= r_byte_cnt + c_BYTE_ONE;
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
      end
      if (w_release) begin
        r_last_served <= w_owner;
      end
      if (w_timeout_rel && (r_timeout_count != 8'hFF)) begin
        r_timeout_count <= r_timeout_count + 8'd1;
      end
      if (w_len_rel) begin
        r_overlength <= 1'b1;
      end
    end
  end

  assign grant          = w_grant;
  assign timeout_count  = r_timeout_count;
  assign overlength     = r_overlength;
  assign bus.req_ready  = w_ready;
  assign bus.uart_write = r_uart_write;
  assign bus.uart_data  = r_uart_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed scoreboard bench for uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic [7:0] timeout_count;
  logic       overlength;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .TIMEOUT_CYCLES(360),
    .MAX_MSG_LEN   (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .grant        (grant),
    .timeout_count(timeout_count),
    .overlength   (overlength)
  );

  always #5 clk = ~clk;

  // Requester queues hold {last, data}; sb holds bytes owed to the FIFO.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] sb[$];
  logic [7:0] out_log[$];
  logic [1:0] grant_log[$];
  logic [7:0] exp_b[$];
  logic [1:0] exp_g[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit idle_now();
    return (q0.size() == 0) && (q1.size() == 0) && (sb.size() == 0) &&
           (grant === 2'b00) && (bus.uart_write === 1'b0);
  endfunction

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!idle_now() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, {31'd0, idle_now()}, 32'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g);
    int n;
    n = 0;
    while (grant !== g && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, grant}, {30'd0, g});
  endtask

  task automatic count_grant(input logic [1:0] g, output int n);
    n = 0;
    while (grant === g && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    grant_log.delete();
    exp_b.delete();
    exp_g.delete();
  endtask

  task automatic check_logs(input string tag);
    int bad;
    check({tag, "_byte_count"}, out_log.size(), exp_b.size());
    bad = 0;
    for (int i = 0; i < out_log.size() && i < exp_b.size(); i++)
      if (out_log[i] !== exp_b[i]) bad++;
    check({tag, "_byte_mismatches"}, bad, 0);
    check({tag, "_grant_count"}, grant_log.size(), exp_g.size());
    bad = 0;
    for (int i = 0; i < grant_log.size() && i < exp_g.size(); i++)
      if (grant_log[i] !== exp_g[i]) bad++;
    check({tag, "_grant_mismatches"}, bad, 0);
  endtask

  // Requester model: presents queue heads and records accepted bytes.
  initial begin : requesters
    logic [8:0] h0;
    logic [8:0] h1;
    bus.req_valid = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;
    bus.req_last  = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      h0 = (q0.size() != 0) ? q0[0] : 9'h000;
      h1 = (q1.size() != 0) ? q1[0] : 9'h000;
      bus.req_valid = {q1.size() != 0, q0.size() != 0};
      bus.req_data0 = h0[7:0];
      bus.req_data1 = h1[7:0];
      bus.req_last  = {h1[8], h0[8]};
      #2;
      if (!reset && bus.req_valid[0] && bus.req_ready[0]) begin
        sb.push_back(h0[7:0]);
        void'(q0.pop_front());
      end
      if (!reset && bus.req_valid[1] && bus.req_ready[1]) begin
        sb.push_back(h1[7:0]);
        void'(q1.pop_front());
      end
    end
  end

  // FIFO-side monitor: every write must match the oldest accepted byte.
  initial begin : monitor
    logic [1:0] prev_grant;
    prev_grant = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.uart_write === 1'b1) begin
        out_log.push_back(bus.uart_data);
        check("write_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) check("write_data", {24'd0, bus.uart_data}, {24'd0, sb.pop_front()});
      end
      if (grant !== prev_grant && grant !== 2'b00) grant_log.push_back(grant);
      prev_grant = grant;
    end
  end

  initial begin : stimulus
    int cyc;
    reset = 1'b1;
    bus.uart_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_write", {31'd0, bus.uart_write}, 32'd0);
    check("rst_data", {24'd0, bus.uart_data}, 32'd0);
    check("rst_timeouts", {24'd0, timeout_count}, 32'd0);
    check("rst_overlength", {31'd0, overlength}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {30'd0, bus.req_ready}, 32'd0);

    // Simultaneous requests: requester 0 wins the first tie, one-cycle arbitration.
    clear_logs();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b1, 8'h42});
    q1.push_back({1'b1, 8'h5A});
    @(negedge clk);
    check("t033_arb_latency", {30'd0, grant}, 32'd1);
    wait_drain("t033");
    exp_b.push_back(8'h41); exp_b.push_back(8'h42); exp_b.push_back(8'h5A);
    exp_g.push_back(2'b01); exp_g.push_back(2'b10);
    check_logs("t033");

    // Round robin with both requesters sending single-byte messages.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 8'hA0 + 8'(i)});
      q1.push_back({1'b1, 8'hB0 + 8'(i)});
      exp_b.push_back(8'hA0 + 8'(i));
      exp_b.push_back(8'hB0 + 8'(i));
      exp_g.push_back(2'b01);
      exp_g.push_back(2'b10);
    end
    wait_drain("t034");
    check_logs("t034");

    // FIFO almost-full stall of five cycles in the middle of a message.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({i == 3, 8'h10 + 8'(i)});
      exp_b.push_back(8'h10 + 8'(i));
    end
    exp_g.push_back(2'b01);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.uart_write !== 1'b1 && cyc < 50);
    check("t036_first_write", {31'd0, bus.uart_write}, 32'd1);
    bus.uart_full = 1'b1;
    #2;
    check("t036_stall_ready", {30'd0, bus.req_ready}, 32'd0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      #2;
      check("t036_stall_ready", {30'd0, bus.req_ready}, 32'd0);
      check("t036_stall_write", {31'd0, bus.uart_write}, 32'd0);
    end
    @(negedge clk);
    bus.uart_full = 1'b0;
    wait_drain("t036");
    check_logs("t036");

    // Last marker on exactly the maximum length is an ordinary release.
    clear_logs();
    for (int i = 0; i < 64; i++) begin
      q0.push_back({i == 63, 8'(i)});
      exp_b.push_back(8'(i));
    end
    exp_g.push_back(2'b01);
    wait_drain("t027");
    check_logs("t027");
    check("t027_overlength", {31'd0, overlength}, 32'd0);

    // 65 bytes without an early last: forced release after 64, then re-grant.
    clear_logs();
    for (int i = 0; i < 65; i++) begin
      q1.push_back({i == 64, 8'h80 + 8'(i)});
      exp_b.push_back(8'h80 + 8'(i));
    end
    exp_g.push_back(2'b10);
    exp_g.push_back(2'b10);
    wait_grant("t037_granted", 2'b10);
    count_grant(2'b10, cyc);
    check("t037_first_grant_cycles", cyc, 64);
    check("t037_overlength", {31'd0, overlength}, 32'd1);
    wait_drain("t037");
    check_logs("t037");

    // Timeout: one byte then silence; 1 transfer cycle + 360 idle cycles granted.
    clear_logs();
    q0.push_back({1'b0, 8'h77});
    q1.push_back({1'b1, 8'h88});
    exp_b.push_back(8'h77); exp_b.push_back(8'h88);
    exp_g.push_back(2'b01); exp_g.push_back(2'b10);
    wait_grant("t035_granted", 2'b01);
    count_grant(2'b01, cyc);
    check("t035_grant_cycles", cyc, 361);
    check("t035_timeouts", {24'd0, timeout_count}, 32'd1);
    wait_drain("t035");
    check_logs("t035");
    check("t035_overlength_sticky", {31'd0, overlength}, 32'd1);

    // Reset one cycle after a transfer aborts the grant.
    clear_logs();
    for (int i = 0; i < 3; i++) q0.push_back({i == 2, 8'hC0 + 8'(i)});
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.uart_write !== 1'b1 && cyc < 50);
    check("t038_first_write", {31'd0, bus.uart_write}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t038_write_after_reset", {31'd0, bus.uart_write}, 32'd0);
    check("t038_grant_after_reset", {30'd0, grant}, 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("t038_no_pending", sb.size(), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t038_idle_grant", {30'd0, grant}, 32'd0);
    check("t038_timeouts", {24'd0, timeout_count}, 32'd0);
    check("t038_overlength", {31'd0, overlength}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
